// File: rtl/pixel_writer_pkg.sv
// Shared types and constants for the edge-detection write-back path.
// State encoding is 3 bits wide so it lines up with the controller's state_o.
package pixel_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_DONE = 3'd2
  } pw_state_e;

  localparam int unsigned DEF_OUT_ROW = 538;
  localparam int unsigned DEF_OUT_COL = 538;
  localparam int unsigned DEF_ADDR_W  = 19;
  localparam int unsigned CNT_W       = 10;
  localparam int unsigned PIX_W       = 8;

endpackage

// File: rtl/pixel_writer.sv
// Raster-order write-back of the Sobel pixel stream into the result BRAM.
// One pixel per cycle, one cycle write latency, no backpressure; stray pixels set a sticky error.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int unsigned OUT_ROW   = DEF_OUT_ROW,
  parameter int unsigned OUT_COL   = DEF_OUT_COL,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  pixel_i,
  input  logic              pixel_en_i,
  input  logic              wb_run_i,
  output logic              wb_done_o,
  output logic              err_o,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [PIX_W-1:0]  d2mem_o,
  output logic [CNT_W-1:0]  cnt_row_o,
  output logic [CNT_W-1:0]  cnt_col_o
);

  pw_state_e         state_q, state_d;
  logic [CNT_W-1:0]  row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d, waddr_q;
  logic [PIX_W-1:0]  dat_q;
  logic              wr_q, err_q;
  logic              accept, col_last, frame_last;

  assign accept     = (state_q == ST_RUN) && wb_run_i && pixel_en_i;
  assign col_last   = (col_q == CNT_W'(OUT_COL - 1));
  assign frame_last = accept && col_last && (row_q == CNT_W'(OUT_ROW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (wb_run_i) state_d = ST_RUN;
      ST_RUN: begin
        if (!wb_run_i)      state_d = ST_IDLE;
        else if (frame_last) state_d = ST_DONE;
      end
      ST_DONE: if (!wb_run_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_done_o = (state_q == ST_DONE);
  end

  // Counters sit at the frame origin whenever no frame is in progress, so RUN entry needs no load.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (state_q != ST_RUN || !wb_run_i || frame_last) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = ADDR_W'(BASE_ADDR);
    end else if (accept) begin
      addr_d = addr_q + ADDR_W'(1);
      if (col_last) begin
        col_d = '0;
        row_d = row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      wr_q    <= 1'b0;
      waddr_q <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
      wr_q   <= accept;
      if (accept) begin
        waddr_q <= addr_q;
        dat_q   <= pixel_i;
      end
      if (pixel_en_i && state_q != ST_RUN) err_q <= 1'b1;
    end
  end

  assign ena_o     = wr_q;
  assign wea_o     = wr_q;
  assign addr_o    = waddr_q;
  assign d2mem_o   = dat_q;
  assign err_o     = err_q;
  assign cnt_row_o = row_q;
  assign cnt_col_o = col_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: two instances (base 0 and base 100) on a 4x3 frame.
module tb_pixel_writer;

  localparam int ROWS   = 4;
  localparam int COLS   = 3;
  localparam int NPIX   = ROWS * COLS;
  localparam int BASE_B = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pixel_i = 8'd0;
  logic       pixel_en_i = 1'b0;
  logic       wb_run_i = 1'b0;

  logic        done_a, err_a, ena_a, wea_a, done_b, err_b, ena_b, wea_b;
  logic [18:0] addr_a, addr_b;
  logic [7:0]  dat_a, dat_b;
  logic [9:0]  row_a, col_a, row_b, col_b;

  pixel_writer #(.OUT_ROW(ROWS), .OUT_COL(COLS), .ADDR_W(19), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .pixel_i(pixel_i), .pixel_en_i(pixel_en_i), .wb_run_i(wb_run_i),
    .wb_done_o(done_a), .err_o(err_a), .ena_o(ena_a), .wea_o(wea_a), .addr_o(addr_a),
    .d2mem_o(dat_a), .cnt_row_o(row_a), .cnt_col_o(col_a));

  pixel_writer #(.OUT_ROW(ROWS), .OUT_COL(COLS), .ADDR_W(19), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .pixel_i(pixel_i), .pixel_en_i(pixel_en_i), .wb_run_i(wb_run_i),
    .wb_done_o(done_b), .err_o(err_b), .ena_o(ena_b), .wea_o(wea_b), .addr_o(addr_b),
    .d2mem_o(dat_b), .cnt_row_o(row_b), .cnt_col_o(col_b));

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] dat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: phase 0 idle, 1 frame open, 2 frame complete; m_n = pixels taken so far.
  int         m_phase = 0;
  int         m_n     = 0;
  bit         m_err   = 1'b0;
  logic [7:0] exp_mem[NPIX];
  logic [7:0] act_mem[NPIX];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit run, input bit en, input logic [7:0] pix);
    case (m_phase)
      0: begin
        if (en) m_err = 1'b1;
        if (run) begin m_phase = 1; m_n = 0; end
      end
      1: begin
        if (!run) begin
          m_phase = 0;
          m_n     = 0;
        end else if (en) begin
          q_a.push_back('{m_n, pix});
          q_b.push_back('{m_n, pix});
          exp_mem[m_n] = pix;
          m_n++;
          if (m_n == NPIX) begin m_phase = 2; m_n = 0; end
        end
      end
      default: begin
        if (en) m_err = 1'b1;
        if (!run) m_phase = 0;
      end
    endcase
  endtask

  task automatic cycle(input bit run, input bit en, input logic [7:0] pix);
    wb_run_i   = run;
    pixel_en_i = en;
    pixel_i    = pix;
    @(posedge clk);
    model_step(run, en, pix);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("done_a", {31'd0, done_a}, {31'd0, m_phase == 2});
    chk("done_b", {31'd0, done_b}, {31'd0, m_phase == 2});
    chk("err_a", {31'd0, err_a}, {31'd0, m_err});
    if (m_phase != 2) begin
      chk("row_a", {22'd0, row_a}, m_n / COLS);
      chk("col_a", {22'd0, col_a}, m_n % COLS);
    end
    if (ena_a || wea_a) begin
      if (q_a.size() == 0) chk("spurious_write_a", {13'd0, addr_a}, 32'hFFFF_FFFF);
      else begin
        e = q_a.pop_front();
        chk("ena_a", {31'd0, ena_a}, 1);
        chk("wea_a", {31'd0, wea_a}, 1);
        chk("addr_a", {13'd0, addr_a}, e.idx);
        chk("data_a", {24'd0, dat_a}, {24'd0, e.dat});
        if (addr_a < NPIX) act_mem[addr_a] = dat_a;
      end
    end
    if (ena_b || wea_b) begin
      if (q_b.size() == 0) chk("spurious_write_b", {13'd0, addr_b}, 32'hFFFF_FFFF);
      else begin
        e = q_b.pop_front();
        chk("we_b", {30'd0, ena_b, wea_b}, 3);
        chk("addr_b", {13'd0, addr_b}, BASE_B + e.idx);
        chk("data_b", {24'd0, dat_b}, {24'd0, e.dat});
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < NPIX; i++) begin
      act_mem[i] = 'x;
      exp_mem[i] = 'x;
    end
  endtask

  task automatic mem_check();
    for (int i = 0; i < NPIX; i++) chk("bram_readback", {24'd0, act_mem[i]}, {24'd0, exp_mem[i]});
  endtask

  // gap_mode: 0 continuous, 1 one-on/two-off, 2 random gaps
  task automatic frame(input int gap_mode, input bit rand_dat);
    logic [7:0] pix;
    int         g;
    clear_mem();
    cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < NPIX; i++) begin
      pix = rand_dat ? 8'($urandom) : 8'(8'h10 + i);
      cycle(1'b1, 1'b1, pix);
      g = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (g) cycle(1'b1, 1'b0, 8'($urandom));
    end
    cycle(1'b1, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 8'd0);
    mem_check();
  endtask

  task automatic check_all_zero();
    chk("rst_done", {31'd0, done_a}, 0);
    chk("rst_err", {31'd0, err_a}, 0);
    chk("rst_we", {30'd0, ena_a, wea_a}, 0);
    chk("rst_addr", {13'd0, addr_a}, 0);
    chk("rst_data", {24'd0, dat_a}, 0);
    chk("rst_cnt", {12'd0, row_a, col_a}, 0);
    chk("rst_addr_b", {13'd0, addr_b}, 0);
  endtask

  initial begin
    #1;
    check_all_zero();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    frame(0, 1'b0);
    frame(1, 1'b0);
    frame(2, 1'b1);

    // abort after 5 pixels, then restart from the origin
    cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'($urandom));
    cycle(1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 8'd0);
    frame(0, 1'b1);

    // stray pixel in IDLE, then in DONE, then run+pixel together from IDLE
    cycle(1'b0, 1'b1, 8'h55);
    clear_mem();
    cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < NPIX; i++) cycle(1'b1, 1'b1, 8'($urandom));
    cycle(1'b1, 1'b1, 8'hAA);
    cycle(1'b1, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 8'd0);
    mem_check();
    cycle(1'b1, 1'b1, 8'h77);
    cycle(1'b0, 1'b0, 8'd0);
    frame(2, 1'b1);

    // asynchronous reset mid-frame after 7 pixels
    cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 8'($urandom));
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    m_phase = 0;
    m_n     = 0;
    m_err   = 1'b0;
    chk("queue_before_reset", q_a.size() + q_b.size(), 0);
    q_a.delete();
    q_b.delete();
    #1;
    check_all_zero();
    wb_run_i   = 1'b0;
    pixel_en_i = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 8'd0);
    frame(1, 1'b1);

    repeat (3) cycle(1'b0, 1'b0, 8'd0);
    chk("queue_drained", q_a.size() + q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

Write-back memory controller for the edge-detection datapath. Consumes the 8-bit pixel stream `PIXEL_O`/`PIXEL_EN_O` from SOBEL_TOP and writes it raster-order into a single-port result BRAM. It is the write-side counterpart of `memory_controller`, which reads the source image and streams it toward the core. The block is started by the controller and reports frame completion back to it.

## Interface
- `OUT_ROW`, 538: rows per output frame (540 minus the 3x3 border).
- `OUT_COL`, 538: columns per output frame.
- `ADDR_W`, 19: BRAM address width.
- `BASE_ADDR`, 0: BRAM address of pixel (0,0).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pixel_i`  in  8  pixel from SOBEL_TOP.
- `pixel_en_i`  in  1  `pixel_i` valid this cycle.
- `wb_run_i`  in  1  from controller; level, high for the whole frame.
- `wb_done_o`  out  1  frame fully written; held until `wb_run_i` falls.
- `err_o`  out  1  sticky: pixel arrived outside RUN; cleared only by reset.
- `ena_o`  out  1  BRAM enable.
- `wea_o`  out  1  BRAM write enable.
- `addr_o`  out  ADDR_W  BRAM address.
- `d2mem_o`  out  8  BRAM write data.
- `cnt_row_o`  out  10  debug: current row.
- `cnt_col_o`  out  10  debug: current column.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when `wb_run_i`=1. On entry, row, column and address counters load 0, 0 and `BASE_ADDR`.
- RUN: each cycle with `pixel_en_i`=1 accepts one pixel. Accepting a pixel registers `ena_o`=`wea_o`=1, `addr_o`=current address and `d2mem_o`=`pixel_i`, then advances the counters.
- Column wraps `OUT_COL`-1 -> 0 and increments the row. The address is a running increment (no multiplier): `addr` = `BASE_ADDR` + row·`OUT_COL` + col.
- Cycles with `pixel_en_i`=0 in RUN drive `ena_o`=`wea_o`=0; `addr_o` and `d2mem_o` hold their values. Gaps of any length are legal.
- RUN -> DONE when the pixel at (`OUT_ROW`-1, `OUT_COL`-1) is accepted.
- DONE: `wb_done_o`=1 and no writes. DONE -> IDLE when `wb_run_i`=0.
- RUN -> IDLE when `wb_run_i` falls mid-frame (abort):
  - counters clear;
  - a write already registered still completes;
  - no further writes are issued.
- `pixel_en_i`=1 in IDLE or DONE: pixel dropped, no write, `err_o` set.
- Width rule: `BASE_ADDR` + `OUT_ROW`·`OUT_COL` - 1 < 2^`ADDR_W`. Defaults give 289443 < 524288.

## Timing
- Reset values: all outputs 0, `addr_o`=0, state IDLE. Reset takes effect immediately and asynchronously, including mid-frame. A frame interrupted by reset is not resumed.
- Write latency: a pixel sampled at edge N appears on the BRAM port during cycle N..N+1 and commits at edge N+1.
- Throughput: one pixel per cycle, no backpressure.
- `wb_done_o` rises at the edge that accepts the last pixel. The last write commits at the following edge, while `wb_done_o` is already high.
- `wb_run_i` high and `pixel_en_i`=1 in the same cycle while in IDLE: the pixel is dropped and `err_o` is set. The first pixel is accepted no earlier than the cycle after RUN is entered.
- `wb_run_i` re-asserted in the same cycle DONE exits: IDLE is visited for one cycle, then RUN.
- Debug counters show the coordinates of the next pixel to be accepted.

## Structure
- Shared package: FSM state encoding (IDLE=0, RUN=1, DONE=2, 3 bits to match the controller's `state_o`), default frame dimensions and the BRAM address width constant.
- Single module; no sub-module needed. The raster counter (row/col/address) may be split out as `raster_cnt` if `memory_controller` adopts it too.

## Test plan
- `OUT_ROW`=4, `OUT_COL`=3, `BASE_ADDR`=0, continuous stream of 12 pixels 0x10..0x1B -> 12 writes at addresses 0..11 with matching data; `wb_done_o` rises on the 12th acceptance; BRAM readback matches.
- Same frame with `pixel_en_i` 1-on/2-off -> identical BRAM contents; `wea_o` never high in gap cycles; addresses strictly sequential.
- `BASE_ADDR`=100, 4x3 frame -> writes to 100..111; the column wrap at col 2 -> 0 increments the row.
- `wb_run_i` dropped after 5 pixels -> exactly 5 writes (addr 0..4), state IDLE, no `wb_done_o`. Restarting writes again from addr 0.
- Pixel pulsed in IDLE and in DONE -> no BRAM access, `err_o`=1 and sticky until `rst_n`=0.
- `rst_n` asserted mid-frame after 7 pixels -> all outputs 0 immediately; after release, a new run writes from addr 0.
